// File: rtl/t_ff_bank.sv
// t_ff_bank: a bank of WIDTH toggle flip-flops.
// The bank can toggle each channel on its own, count as one cascaded counter,
// take a parallel load, or apply per-bit set/clear. q, the rise/fall pulses and
// the wrap pulse are all registered, so no input reaches an output combinationally.
module t_ff_bank #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_TOGGLE  = 2'b00,
        MODE_CASCADE = 2'b01,
        MODE_LOAD    = 2'b10,
        MODE_SETCLR  = 2'b11
    } mode_t;

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             carry;

    // Work out the next q and wrap from the mode; with en low q simply holds.
    // The cascade carry runs one channel at a time so any WIDTH down to 1 works.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        carry     = t[0];
        if (en) begin
            case (mode_t'(mode))
                MODE_TOGGLE: begin
                    q_next = q ^ t;
                end
                MODE_CASCADE: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        q_next[i] = q[i] ^ carry;
                        carry     = carry & q[i];
                    end
                    wrap_next = t[0] & (&q);
                end
                MODE_LOAD: begin
                    q_next = d;
                end
                MODE_SETCLR: begin
                    q_next = (q | d) & ~t;
                end
                default: begin
                    q_next = q;
                end
            endcase
        end
    end

    // Register q and the edge pulses together; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q      <= INIT;
            q_rise <= '0;
            q_fall <= '0;
            wrap   <= 1'b0;
        end else begin
            q      <= q_next;
            q_rise <= ~q & q_next;
            q_fall <= q & ~q_next;
            wrap   <= wrap_next;
        end
    end

endmodule

// File: tb/tb_t_ff_bank.sv
// Testbench for t_ff_bank: a directed vector table, hand-written cascade
// sequences, and random stimulus compared against a simple arithmetic model.
// Two instances share the inputs: one with INIT=0, one with INIT=4'h3.
module tb_t_ff_bank;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [3:0] t;
    logic [3:0] d;
    logic [3:0] q0, rise0, fall0;
    logic       wrap0;
    logic [3:0] q3, rise3, fall3;
    logic       wrap3;

    int checks;
    int errors;

    // Model state for both instances: index 0 is INIT=0, index 1 is INIT=3.
    logic [3:0] mq [2];
    logic [3:0] mr [2];
    logic [3:0] mf [2];
    logic       mw [2];

    typedef struct {
        logic       rst;
        logic       ena;
        logic [1:0] md;
        logic [3:0] tv;
        logic [3:0] dv;
        logic [3:0] eq;
        logic [3:0] er;
        logic [3:0] ef;
        logic       ew;
    } vec_t;

    vec_t vecs[$];

    t_ff_bank #(.WIDTH(4), .INIT(4'h0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .t(t), .d(d),
        .q(q0), .q_rise(rise0), .q_fall(fall0), .wrap(wrap0)
    );

    t_ff_bank #(.WIDTH(4), .INIT(4'h3)) dut3 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .t(t), .d(d),
        .q(q3), .q_rise(rise3), .q_fall(fall3), .wrap(wrap3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and report a FAIL line when it differs.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the reference model by one clock using the rules in plain arithmetic.
    task automatic modelStep();
        logic [3:0] init_val;
        logic [3:0] nq;
        for (int k = 0; k < 2; k++) begin
            init_val = (k == 0) ? 4'h0 : 4'h3;
            if (!reset) begin
                mq[k] = init_val;
                mr[k] = 4'h0;
                mf[k] = 4'h0;
                mw[k] = 1'b0;
            end else if (!en) begin
                mr[k] = 4'h0;
                mf[k] = 4'h0;
                mw[k] = 1'b0;
            end else begin
                mw[k] = 1'b0;
                case (mode)
                    2'b00: nq = mq[k] ^ t;
                    2'b01: begin
                        nq    = 4'((int'(mq[k]) + int'(t[0])) % 16);
                        mw[k] = (t[0] == 1'b1) && (mq[k] == 4'hF);
                    end
                    2'b10: nq = d;
                    default: nq = (mq[k] | d) & ~t;
                endcase
                mr[k] = ~mq[k] & nq;
                mf[k] = mq[k] & ~nq;
                mq[k] = nq;
            end
        end
    endtask

    // Check both instances against the model.
    task automatic checkModel(input string tag);
        checkOutput({tag, ".q0"},     32'(q0),    32'(mq[0]));
        checkOutput({tag, ".rise0"},  32'(rise0), 32'(mr[0]));
        checkOutput({tag, ".fall0"},  32'(fall0), 32'(mf[0]));
        checkOutput({tag, ".wrap0"},  32'(wrap0), 32'(mw[0]));
        checkOutput({tag, ".q3"},     32'(q3),    32'(mq[1]));
        checkOutput({tag, ".rise3"},  32'(rise3), 32'(mr[1]));
        checkOutput({tag, ".fall3"},  32'(fall3), 32'(mf[1]));
        checkOutput({tag, ".wrap3"},  32'(wrap3), 32'(mw[1]));
    endtask

    // Drive inputs, clock once, sample 1 time unit after the edge, update the model.
    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                                 input logic [3:0] tt, input logic [3:0] dd);
        reset = r;
        en    = e;
        mode  = m;
        t     = tt;
        d     = dd;
        @(posedge clk);
        #1;
        modelStep();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        en     = 1'b0;
        mode   = 2'b00;
        t      = 4'h0;
        d      = 4'h0;

        // Directed vectors for the INIT=0 instance: rst, en, mode, t, d, q, rise, fall, wrap.
        vecs.push_back('{1'b0, 1'b1, 2'b10, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 2'b10, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'b00, 4'h5, 4'h0, 4'h5, 4'h5, 4'h0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'b00, 4'h5, 4'h0, 4'h0, 4'h0, 4'h5, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'b00, 4'h5, 4'h0, 4'h5, 4'h5, 4'h0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'b10, 4'h0, 4'hA, 4'hA, 4'hA, 4'h5, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'b11, 4'h8, 4'h5, 4'h7, 4'h5, 4'h8, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'b10, 4'h0, 4'h3, 4'h3, 4'h0, 4'h4, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'b11, 4'h3, 4'h3, 4'h0, 4'h0, 4'h3, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'b01, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'b10, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 2'b00, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].ena, vecs[i].md, vecs[i].tv, vecs[i].dv);
            checkOutput($sformatf("vec%0d.q", i),    32'(q0),    32'(vecs[i].eq));
            checkOutput($sformatf("vec%0d.rise", i), 32'(rise0), 32'(vecs[i].er));
            checkOutput($sformatf("vec%0d.fall", i), 32'(fall0), 32'(vecs[i].ef));
            checkOutput($sformatf("vec%0d.wrap", i), 32'(wrap0), 32'(vecs[i].ew));
            checkModel($sformatf("vec%0d.model", i));
        end

        // Cascade count from 0 with a 3-cycle enable pause at 7, through the wrap.
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b1, 1'b1, 2'b01, 4'h1, 4'h0);
            checkOutput($sformatf("casc%0d.q", i),    32'(q0),    32'(i));
            checkOutput($sformatf("casc%0d.wrap", i), 32'(wrap0), 32'(0));
            checkModel("casc");
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 2'b01, 4'h1, 4'h0);
            checkOutput("pause.q",    32'(q0),    32'(7));
            checkOutput("pause.rise", 32'(rise0), 32'(0));
            checkOutput("pause.fall", 32'(fall0), 32'(0));
            checkModel("pause");
        end
        for (int i = 8; i <= 16; i++) begin
            applyStimulus(1'b1, 1'b1, 2'b01, 4'h1, 4'h0);
            checkOutput($sformatf("casc%0d.q", i),    32'(q0),    32'(i % 16));
            checkOutput($sformatf("casc%0d.wrap", i), 32'(wrap0), 32'(i == 16 ? 1 : 0));
            if (i == 16)
                checkOutput("wrap.fall", 32'(fall0), 32'(4'hF));
            checkModel("casc");
        end

        // INIT=3 instance: count to 9, reset mid-count, then resume from INIT.
        applyStimulus(1'b0, 1'b1, 2'b01, 4'h1, 4'h0);
        checkOutput("init3.q", 32'(q3), 32'(4'h3));
        for (int i = 4; i <= 9; i++) begin
            applyStimulus(1'b1, 1'b1, 2'b01, 4'h1, 4'h0);
            checkOutput($sformatf("init3.count%0d", i), 32'(q3), 32'(i));
        end
        applyStimulus(1'b0, 1'b1, 2'b01, 4'h1, 4'h0);
        checkOutput("midreset.q",    32'(q3),    32'(4'h3));
        checkOutput("midreset.wrap", 32'(wrap3), 32'(0));
        checkOutput("midreset.rise", 32'(rise3), 32'(0));
        checkOutput("midreset.fall", 32'(fall3), 32'(0));
        checkModel("midreset");
        applyStimulus(1'b1, 1'b1, 2'b01, 4'h1, 4'h0);
        checkOutput("resume.q4", 32'(q3), 32'(4'h4));
        applyStimulus(1'b1, 1'b1, 2'b01, 4'h1, 4'h0);
        checkOutput("resume.q5", 32'(q3), 32'(4'h5));
        checkModel("resume");

        // Random stimulus; cascade mode is weighted up so wraps actually occur.
        for (int i = 0; i < 400; i++) begin
            logic       r;
            logic       e;
            logic [1:0] m;
            r = ($urandom_range(0, 39) != 0);
            e = ($urandom_range(0, 7) != 0);
            m = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
            applyStimulus(r, e, m, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            checkModel($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
